// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bundle for seq_shift_add_mult.
// The requester drives the operands and start; the multiplier drives product, done and busy.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] product;
    logic               done;
    logic               busy;

    modport master (
        output start, signed_mode, a, b,
        input  product, done, busy
    );

    modport slave (
        input  start, signed_mode, a, b,
        output product, done, busy
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier with early termination and signed/unsigned mode.
// One multiplier bit per cycle; accepts a new operation in IDLE or DONE.
module seq_shift_add_mult #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    seq_shift_add_mult_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2*WIDTH-1:0] r_a_sh;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg;

    logic               w_accept;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_sgn    = SIGNED_EN && bus.signed_mode;
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

    // The most negative operand negates to itself, which reads correctly as an unsigned magnitude.
    assign w_a_mag = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (r_b == '0) w_next = DONE;
            DONE:    w_next = w_accept ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_sh    <= '0;
            r_p       <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a_sh <= {{WIDTH{1'b0}}, w_a_mag};
            r_b    <= w_b_mag;
            r_p    <= '0;
            r_neg  <= w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end else if (r_state == CALC) begin
            if (r_b != '0) begin
                if (r_b[0]) begin
                    r_p <= r_p + r_a_sh;
                end
                r_a_sh <= r_a_sh << 1;
                r_b    <= r_b >> 1;
            end else begin
                r_product <= r_neg ? -r_p : r_p;
            end
        end
    end

    assign bus.product = r_product;
    assign bus.done    = (r_state == DONE);
    assign bus.busy    = (r_state == CALC);
endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Parametrised sequential multiplier. Successor to the 8-bit repeated-addition multiplier: it multiplies WIDTH-bit operands by shift-and-add, one multiplier bit per cycle, and terminates early once the remaining multiplier bits are zero. It supports a per-operation signed/unsigned mode, captures both operands in parallel on `start`, and accepts back-to-back operations. The controller and datapath live in one block; it replaces the `top` controller/datapath pair wherever a multiply unit is instantiated.

## Interface
- `WIDTH`, default 8: operand width; must be ≥ 2; product is 2*WIDTH.
- `SIGNED_EN`, default 1: when 0, `signed_mode` is ignored and every operation is unsigned.

- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  reset; one clock; reset is asynchronous and active-low.
- `start`  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- `signed_mode`  input  1  1 = two's-complement operands; captured with `start`.
- `a`  input  WIDTH  multiplicand; captured on acceptance.
- `b`  input  WIDTH  multiplier; captured on acceptance.
- `product`  output  2*WIDTH  registered result; holds its value until the next completion.
- `done`  output  1  high for exactly one cycle while in DONE.
- `busy`  output  1  high while in CALC.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Acceptance happens when `start`=1 in IDLE or DONE. It loads:
  - `A_sh` (2*WIDTH) = |a|, zero-extended.
  - `B_r` (WIDTH) = |b|.
  - `P` (2*WIDTH) = 0.
  - `neg` = signed & (a[MSB] ^ b[MSB]).
  - Then the block goes to CALC.
- Magnitudes:
  - In unsigned mode, |x| = x.
  - In signed mode, |x| = two's-complement negation when x[MSB]=1.
  - -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits in WIDTH unsigned bits.
- CALC, when `B_r` != 0:
  - if `B_r[0]`, then P <= P + A_sh (2*WIDTH, no overflow possible);
  - A_sh <= A_sh << 1;
  - B_r <= B_r >> 1;
  - stay in CALC.
- CALC, when `B_r` == 0:
  - product <= neg ? -P : P (2*WIDTH two's complement);
  - go to DONE.
- DONE:
  - `done`=1.
  - With `start`=1, accept a new operation and go to CALC.
  - Otherwise go to IDLE.
- `start` in CALC is ignored; no queuing.
- `a`, `b` and `signed_mode` are don't-care outside the accepting edge.
- Reset asserted at any time (including mid-CALC):
  - outputs go to reset values immediately;
  - the operation in flight is discarded;
  - `product` is not updated.

## Timing
- Reset values: `product`=0, `done`=0, `busy`=0, state IDLE.
- Let k = bit-length of |b| (index of highest set bit + 1; k=0 for b=0).
- CALC lasts k+1 cycles.
- `done` is high in the cycle after the (k+2)th rising edge counted from the accepting edge (accepting edge = edge 1).
  - Minimum latency 2 edges (b=0).
  - Maximum latency WIDTH+2 edges.
- `product` updates on the same edge that raises `done`, and is stable while `done`=1 and afterwards.
- `busy` rises the edge after acceptance and falls on the edge that raises `done`.
- Back-to-back: with `start`=1 during DONE, `busy` is high in the next cycle with no IDLE cycle between operations. `product` keeps the previous result until the new completion.
- `done` and `busy` are never high in the same cycle.

## Test plan
- Unsigned 13×11, WIDTH=8 (k=4):
  - `done` after 6 edges, `product`=0x008F;
  - `busy` high for exactly 5 cycles.
- Signed (−3)×7 (a=0xFD, b=0x07, k=3):
  - `product`=0xFFEB after 5 edges.
- Signed (−128)×(−128):
  - `product`=0x4000, latency 10.
- Unsigned 0xFF×0xFF:
  - `product`=0xFE01, latency 10.
- a=0xFF, b=0 in either mode:
  - `product`=0, `done` after 2 edges.
- Start handling:
  - `start` pulsed during CALC is ignored and the result is unchanged.
  - `start` held through DONE with new operands (5×5) starts immediately; the next `done` shows 0x0019.
  - `product` holds the prior value until that `done`.
- Reset mid-operation:
  - Assert reset mid-CALC; `product`=0, `done`=0 and `busy`=0 asynchronously.
  - After release, 2×3 gives 0x0006.
- WIDTH=16, SIGNED_EN=0 with `signed_mode`=1:
  - 0xFFFF×0xFFFF gives 0xFFFE0001 (unsigned) with latency 18.
